// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/op request channel and result/flag response channel.
// The master side presents operations and consumes results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [4:0]      aluControl;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] aluResult;
  logic            aluZero;
  logic            aluNeg;
  logic            aluCarry;
  logic            aluOverflow;
  logic            aluIllegal;
  logic            busy;

  modport master (
    output in_valid, srcA, srcB, aluControl, out_ready,
    input  in_ready, out_valid, aluResult, aluZero, aluNeg, aluCarry, aluOverflow, aluIllegal, busy
  );

  modport slave (
    input  in_valid, srcA, srcB, aluControl, out_ready,
    output in_ready, out_valid, aluResult, aluZero, aluNeg, aluCarry, aluOverflow, aluIllegal, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered RV32I-style ALU with iterative unsigned multiply/divide behind a valid/ready handshake.
// Single-cycle ops complete on the accept edge; MUL/MULHU/DIVU/REMU iterate one bit per cycle.
module alu_seq #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic        clk,
  input logic        rst,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_MUL   = 5'd10;
  localparam logic [4:0] ALU_MULHU = 5'd11;
  localparam logic [4:0] ALU_DIVU  = 5'd12;
  localparam logic [4:0] ALU_REMU  = 5'd13;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] res_q;
  logic            zero_q, neg_q, carry_q, ovf_q, ill_q;

  // acc holds the product high half / partial remainder, lo the multiplier / quotient
  logic [XLEN-1:0] acc_q, lo_q, opb_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;

  logic            accept;
  logic [XLEN:0]   sum_ext, dif_ext;
  logic [XLEN-1:0] r_res;
  logic            r_carry, r_ovf, r_illegal, r_iter;
  logic [SHW-1:0]  shamt;

  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] step_acc, step_lo, fin_res;

  assign accept = bus.in_valid & bus.in_ready;
  assign shamt  = bus.srcB[SHW-1:0];

  always_comb begin
    sum_ext   = {1'b0, bus.srcA} + {1'b0, bus.srcB};
    dif_ext   = {1'b0, bus.srcA} - {1'b0, bus.srcB};
    r_res     = '0;
    r_carry   = 1'b0;
    r_ovf     = 1'b0;
    r_illegal = 1'b0;
    r_iter    = 1'b0;
    case (bus.aluControl)
      ALU_ADD: begin
        r_res   = sum_ext[XLEN-1:0];
        r_carry = sum_ext[XLEN];
        r_ovf   = (bus.srcA[XLEN-1] == bus.srcB[XLEN-1]) && (sum_ext[XLEN-1] != bus.srcA[XLEN-1]);
      end
      ALU_SUB: begin
        r_res   = dif_ext[XLEN-1:0];
        r_carry = ~dif_ext[XLEN];
        r_ovf   = (bus.srcA[XLEN-1] != bus.srcB[XLEN-1]) && (dif_ext[XLEN-1] != bus.srcA[XLEN-1]);
      end
      ALU_AND:  r_res = bus.srcA & bus.srcB;
      ALU_OR:   r_res = bus.srcA | bus.srcB;
      ALU_XOR:  r_res = bus.srcA ^ bus.srcB;
      ALU_SLL:  r_res = bus.srcA << shamt;
      ALU_SRL:  r_res = bus.srcA >> shamt;
      ALU_SRA:  r_res = $signed(bus.srcA) >>> shamt;
      ALU_SLT:  r_res = {{(XLEN-1){1'b0}}, $signed(bus.srcA) < $signed(bus.srcB)};
      ALU_SLTU: r_res = {{(XLEN-1){1'b0}}, bus.srcA < bus.srcB};
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: begin
        if (MULDIV_EN) r_iter    = 1'b1;
        else           r_illegal = 1'b1;
      end
      default: r_illegal = 1'b1;
    endcase
  end

  // A zero divisor needs no special case: every trial subtract succeeds, giving all-ones
  // quotient and the dividend as remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {acc_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
    step_acc = '0;
    step_lo  = '0;
    if (op_q == ALU_MUL || op_q == ALU_MULHU) begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_acc = div_diff[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_acc = div_sh[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], 1'b0};
    end
    fin_res = (op_q == ALU_MULHU || op_q == ALU_REMU) ? step_acc : step_lo;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = r_iter ? S_BUSY : S_DONE;
      S_BUSY: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: begin
        if (bus.out_ready) begin
          if (accept) state_d = r_iter ? S_BUSY : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else if (accept) begin
      if (r_iter) begin
        acc_q <= '0;
        lo_q  <= bus.srcA;
        opb_q <= bus.srcB;
        cnt_q <= CW'(XLEN-1);
        op_q  <= bus.aluControl;
      end else begin
        res_q   <= r_res;
        zero_q  <= (r_res == '0);
        neg_q   <= r_res[XLEN-1];
        carry_q <= r_carry;
        ovf_q   <= r_ovf;
        ill_q   <= r_illegal;
      end
    end else if (state_q == S_BUSY) begin
      acc_q <= step_acc;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) begin
        res_q   <= fin_res;
        zero_q  <= (fin_res == '0);
        neg_q   <= fin_res[XLEN-1];
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        ill_q   <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q == S_BUSY);
  assign bus.aluResult   = res_q;
  assign bus.aluZero     = zero_q;
  assign bus.aluNeg      = neg_q;
  assign bus.aluCarry    = carry_q;
  assign bus.aluOverflow = ovf_q;
  assign bus.aluIllegal  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, randomized ops against an
// arithmetic reference model, back-to-back throughput, output hold, operand latching and reset abort.
module tb_alu_seq;
  localparam int XLEN = 32;
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULHU = 5'd11;
  localparam logic [4:0] OP_DIVU = 5'd12, OP_REMU = 5'd13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(XLEN)) bus();
  alu_seq #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic bit is_iter(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  // flags packed as {zero, neg, carry, overflow, illegal}
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] flg);
    longint s;
    longint unsigned u;
    logic [63:0] p;
    int sa;
    logic c, v, ill;
    r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      OP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        u = longint'(a) + longint'(b);
        r = a + b; c = (u >= 64'h1_0000_0000); v = (s > SMAX) || (s < SMIN);
      end
      OP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b; c = (a >= b); v = (s > SMAX) || (s < SMIN);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_SLL:   r = a << b[4:0];
      OP_SRL:   r = a >> b[4:0];
      OP_SRA:   begin sa = $signed(a); sa = sa >>> b[4:0]; r = sa; end
      OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      OP_MUL:   begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      OP_MULHU: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      OP_DIVU:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:  r = (b == 0) ? a : a % b;
      default:  ill = 1'b1;
    endcase
    flg = {(r == 0), r[31], c, v, ill};
  endfunction

  // Issues one op, waits for the result and consumes it. lat counts clock edges from the
  // accept edge (inclusive) until out_valid is seen; stall_bad counts waiting cycles in which
  // the block was not busy or offered in_ready.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [4:0] flg,
                        output int lat, output int stall_bad);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.srcA = a; bus.srcB = b; bus.aluControl = op; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.srcA = $urandom; bus.srcB = $urandom; bus.aluControl = 5'($urandom);
    lat = 1; stall_bad = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready || !bus.busy) stall_bad++;
      @(posedge clk); @(negedge clk); lat++;
    end
    res = bus.aluResult;
    flg = {bus.aluZero, bus.aluNeg, bus.aluCarry, bus.aluOverflow, bus.aluIllegal};
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] flg;
    flg = {bus.aluZero, bus.aluNeg, bus.aluCarry, bus.aluOverflow, bus.aluIllegal};
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL reset_valid_busy: out_valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
    else passed++;
    total++;
    if (bus.aluResult !== 32'd0 || flg !== 5'b10000) $display("FAIL reset_outputs: result=%h flags=%b, want 00000000 10000", bus.aluResult, flg);
    else passed++;
    @(negedge clk); rst = 1'b0; @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    else passed++;
  endtask

  task automatic test_directed();
    vec_t dv[13];
    logic [31:0] res, mr;
    logic [4:0] flg, mf;
    int lat, sb, exp_lat;
    dv[0]  = '{OP_ADD,   32'h7FFF_FFFF, 32'h1,          32'h8000_0000};
    dv[1]  = '{OP_SRA,   32'h8000_0000, 32'd31,         32'hFFFF_FFFF};
    dv[2]  = '{OP_SRL,   32'h8000_0000, 32'd31,         32'h1};
    dv[3]  = '{OP_SLT,   32'hFFFF_FFFF, 32'h1,          32'h1};
    dv[4]  = '{OP_SLTU,  32'hFFFF_FFFF, 32'h1,          32'h0};
    dv[5]  = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE};
    dv[6]  = '{OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1};
    dv[7]  = '{OP_DIVU,  32'd100,       32'd7,          32'd14};
    dv[8]  = '{OP_REMU,  32'd100,       32'd7,          32'd2};
    dv[9]  = '{OP_DIVU,  32'd9,         32'd0,          32'hFFFF_FFFF};
    dv[10] = '{OP_REMU,  32'd9,         32'd0,          32'd9};
    dv[11] = '{OP_SLL,   32'h1,         32'd33,         32'h2};
    dv[12] = '{5'd20,    32'd3,         32'd4,          32'h0};
    foreach (dv[i]) begin
      run_op(dv[i].op, dv[i].a, dv[i].b, res, flg, lat, sb);
      model(dv[i].op, dv[i].a, dv[i].b, mr, mf);
      exp_lat = is_iter(dv[i].op) ? XLEN + 1 : 1;
      total++;
      if (res !== dv[i].exp) $display("FAIL dir%0d_result: op=%0d got %h want %h", i, dv[i].op, res, dv[i].exp);
      else passed++;
      total++;
      if (flg !== mf) $display("FAIL dir%0d_flags: op=%0d got %b want %b", i, dv[i].op, flg, mf);
      else passed++;
      total++;
      if (lat !== exp_lat) $display("FAIL dir%0d_latency: op=%0d got %0d want %0d", i, dv[i].op, lat, exp_lat);
      else passed++;
      total++;
      if (sb !== 0) $display("FAIL dir%0d_busy_ready: op=%0d bad cycles %0d want 0", i, dv[i].op, sb);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [4:0] op, flg, mf;
    logic [31:0] a, b, res, mr;
    int lat, sb, exp_lat;
    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (op == OP_DIVU || op == OP_REMU) b = b >> $urandom_range(0, 31);
      run_op(op, a, b, res, flg, lat, sb);
      model(op, a, b, mr, mf);
      exp_lat = is_iter(op) ? XLEN + 1 : 1;
      total++;
      if (res !== mr || flg !== mf || lat !== exp_lat)
        $display("FAIL rand%0d: op=%0d a=%h b=%h got %h/%b/%0d want %h/%b/%0d", k, op, a, b, res, flg, lat, mr, mf, exp_lat);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[10];
    logic [31:0] as[10], bs[10], mr;
    logic [4:0] mf, flg;
    ops[0] = OP_SUB; as[0] = 32'd5; bs[0] = 32'd5;
    ops[1] = OP_SUB; as[1] = 32'd3; bs[1] = 32'd5;
    for (int k = 2; k < 10; k++) begin
      ops[k] = 5'($urandom_range(0, 9)); as[k] = $urandom; bs[k] = $urandom;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        model(ops[k-1], as[k-1], bs[k-1], mr, mf);
        flg = {bus.aluZero, bus.aluNeg, bus.aluCarry, bus.aluOverflow, bus.aluIllegal};
        total++;
        if (bus.out_valid !== 1'b1 || bus.aluResult !== mr || flg !== mf)
          $display("FAIL b2b%0d: valid=%b result=%h flags=%b want 1 %h %b", k-1, bus.out_valid, bus.aluResult, flg, mr, mf);
        else passed++;
      end
      if (k < 10) begin
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b%0d_ready: in_ready=%b want 1", k, bus.in_ready);
        else passed++;
        bus.in_valid = 1'b1; bus.srcA = as[k]; bus.srcB = bs[k]; bus.aluControl = ops[k];
        @(posedge clk); @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_idle: out_valid=%b want 0", bus.out_valid);
    else passed++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [31:0] a, b, mr;
    logic [4:0] mf, flg;
    a = $urandom; b = $urandom;
    model(OP_ADD, a, b, mr, mf);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.srcA = a; bus.srcB = b; bus.aluControl = OP_ADD; bus.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0; bus.srcA = ~a; bus.srcB = ~b; bus.aluControl = OP_SUB;
    for (int k = 0; k < 5; k++) begin
      flg = {bus.aluZero, bus.aluNeg, bus.aluCarry, bus.aluOverflow, bus.aluIllegal};
      total++;
      if (bus.out_valid !== 1'b1 || bus.aluResult !== mr || flg !== mf || bus.in_ready !== 1'b0)
        $display("FAIL hold%0d: valid=%b result=%h flags=%b ready=%b want 1 %h %b 0", k, bus.out_valid, bus.aluResult, flg, bus.in_ready, mr, mf);
      else passed++;
      @(posedge clk); @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL hold_release: out_valid=%b want 0", bus.out_valid);
    else passed++;
  endtask

  task automatic test_operand_latch();
    logic [31:0] mr;
    logic [4:0] mf;
    int ready_seen, n;
    model(OP_DIVU, 32'd1000, 32'd13, mr, mf);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.srcA = 32'd1000; bus.srcB = 32'd13; bus.aluControl = OP_DIVU; bus.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    ready_seen = 0; n = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) ready_seen++;
      bus.srcA = $urandom; bus.srcB = $urandom; bus.aluControl = OP_ADD;
      @(posedge clk); @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.aluResult !== mr || ready_seen !== 0)
      $display("FAIL latch: valid=%b result=%h ready_seen=%0d want 1 %h 0", bus.out_valid, bus.aluResult, ready_seen, mr);
    else passed++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.srcA = 32'd100; bus.srcB = 32'd7; bus.aluControl = OP_DIVU; bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL abort_busy_before: busy=%b want 1", bus.busy);
    else passed++;
    rst = 1'b1; #1;
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.aluZero !== 1'b1)
      $display("FAIL abort_reset_state: busy=%b valid=%b zero=%b want 0 0 1", bus.busy, bus.out_valid, bus.aluZero);
    else passed++;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
    total++;
    if (seen !== 0 || bus.in_ready !== 1'b1) $display("FAIL abort_busy_after: valid cycles=%0d in_ready=%b want 0 1", seen, bus.in_ready);
    else passed++;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.srcA = 32'd1; bus.srcB = 32'd1; bus.aluControl = OP_ADD;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.aluResult !== 32'd2) $display("FAIL abort_done_before: valid=%b result=%h want 1 00000002", bus.out_valid, bus.aluResult);
    else passed++;
    rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (bus.out_valid) seen++; end
    total++;
    if (seen !== 0 || bus.aluResult !== 32'd0) $display("FAIL abort_done_after: valid cycles=%0d result=%h want 0 00000000", seen, bus.aluResult);
    else passed++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.srcA = '0; bus.srcB = '0; bus.aluControl = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_operand_latch();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
